// File: rtl/reverse_pkg.sv
// Shared types and constants for the reversed-number binary-to-BCD converter.
// Holds the FSM state encoding, default sizes and the iteration-counter width helper.
package reverse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGITS = 5;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Purely combinational, no handshake.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/reverse_bcd_conv.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle; result valid WIDTH edges after accept.
// Result is held with out_valid until out_ready; no new input is accepted while converting or holding.
module reverse_bcd_conv
    import reverse_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [2:0]            out_ndig,
    output logic                  busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam int AW = 4 * DIGITS;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    bin_q;
    logic [AW-1:0]       acc_q;
    logic [AW-1:0]       adj;
    logic [AW-1:0]       res_q;
    logic [CW-1:0]       cnt_q;
    logic [AW+WIDTH-1:0] shifted;
    logic                last_step;
    logic                accept;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .din  (acc_q[4*g +: 4]),
                .dout (adj[4*g +: 4])
            );
        end
    endgenerate

    // Shifting the concatenation drops the accumulator MSB, which legal sizing keeps zero.
    assign shifted   = {adj, bin_q} << 1;
    assign last_step = (cnt_q == CW'(WIDTH - 1));
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = CONV;
            end
            CONV: begin
                busy = 1'b1;
                if (last_step) state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else if (accept) begin
            bin_q <= in_data;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == CONV) begin
            bin_q <= shifted[WIDTH-1:0];
            acc_q <= shifted[AW+WIDTH-1:WIDTH];
            cnt_q <= cnt_q + CW'(1);
            // Result lives in its own register so bcd stays put after the handshake.
            if (last_step) res_q <= shifted[AW+WIDTH-1:WIDTH];
        end
    end

    assign bcd = res_q;

    always_comb begin
        out_ndig = 3'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (res_q[4*i +: 4] != 4'd0) out_ndig = 3'(i + 1);
        end
    end

endmodule
